conv_host_sequencer: RTL and testbench

Host-side sequencer that drives the conv accelerator's memory and control ports from the opposite end. It accepts an input image as a byte stream, packs it into 32-bit words on the accelerator's input-memory write port, and pulses the accelerator's start. After the accelerator's done, it reads the result bytes back through the output-memory read port and emits them as a byte stream with last-marking. It sits between the system stream fabric and one conv instance.

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_byte_packer.sv | 77 +++++++
 rtl/conv_host_sequencer.sv | 178 +++++++++++++++++
 tb/tb_conv_host_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv host sequencer: FSM encodings, lane count, address width helper.
package conv_pkg;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StKick  = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;

  localparam int unsigned Lanes = 4;

  // One extra bit beyond the byte index range, matching the accelerator's port width.
  function automatic int unsigned addr_w(input int unsigned dsize);
    return $clog2(dsize) + 1;
  endfunction

endpackage

// File: rtl/conv_byte_packer.sv
// Packs a byte stream into 32-bit words, little-endian lanes, flushing a zero-filled partial
// word on the last byte. Emits a registered word, one-cycle valid and the word index.
module conv_byte_packer
  import conv_pkg::*;
#(
  parameter int unsigned IdxW = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            byte_valid_i,
  input  logic [7:0]      byte_i,
  input  logic            byte_last_i,
  output logic [31:0]     word_o,
  output logic            word_valid_o,
  output logic [IdxW-1:0] word_idx_o
);

  logic [1:0]      lane_q, lane_d;
  logic [23:0]     acc_q, acc_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] widx_q, widx_d;
  logic [31:0]     word_q, word_d;
  logic            valid_q, valid_d;
  logic [31:0]     merged;

  always_comb begin
    merged  = {8'h00, acc_q} | ({24'h000000, byte_i} << {lane_q, 3'b000});
    lane_d  = lane_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    widx_d  = widx_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      lane_d = 2'd0;
      acc_d  = 24'h000000;
      idx_d  = '0;
    end else if (byte_valid_i) begin
      if (lane_q == 2'(Lanes - 1) || byte_last_i) begin
        // Accumulator lanes not yet written are still zero, giving the zero fill.
        word_d  = merged;
        valid_d = 1'b1;
        widx_d  = idx_q;
        idx_d   = idx_q + 1'b1;
        lane_d  = 2'd0;
        acc_d   = 24'h000000;
      end else begin
        acc_d  = merged[23:0];
        lane_d = lane_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q  <= 2'd0;
      acc_q   <= 24'h000000;
      idx_q   <= '0;
      widx_q  <= '0;
      word_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      widx_q  <= widx_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign word_idx_o   = widx_q;

endmodule

// File: rtl/conv_host_sequencer.sv
// Host-side sequencer: loads an image into the conv accelerator, kicks it, waits for done and
// streams the result window back out with last-marking.
module conv_host_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned DSIZE = 1024,
  localparam int unsigned AW = addr_w(DSIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [7:0]    data_width,
  input  logic [7:0]    data_height,
  input  logic [7:0]    result_width,
  input  logic [7:0]    result_height,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic [AW-1:0] mi_addr,
  output logic [31:0]   mi_data,
  output logic          mi_wr,
  output logic [AW-1:0] mo_addr,
  input  logic [31:0]   mo_data,
  output logic          conv_start,
  input  logic          conv_done,
  output logic          busy,
  output logic          done,
  output logic          err
);

  logic [2:0]    state_q, state_d;
  logic [7:0]    dw_q, dw_d, rw_q, rw_d, rh_q, rh_d;
  logic [15:0]   n_q, n_d, cnt_q, cnt_d;
  logic          s_ready_q, s_ready_d, start_q, start_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          m_valid_q, m_valid_d, m_last_q, m_last_d, pend_q, pend_d;
  logic [7:0]    m_data_q, m_data_d, col_q, col_d, row_q, row_d;
  logic [15:0]   base_q, base_d;
  logic [AW-1:0] mo_addr_q, mo_addr_d;

  logic [15:0]   n_go;
  logic          s_hs, m_hs, byte_last, rd_last, pack_clear;
  logic          unused_mo_hi;

  assign n_go       = 16'(data_width) * 16'(data_height);
  assign s_hs       = s_valid && s_ready_q;
  assign m_hs       = m_valid_q && m_ready;
  assign byte_last  = (cnt_q == n_q - 16'd1);
  assign rd_last    = (col_q == rw_q) && (row_q == rh_q);
  assign pack_clear = (state_q == StIdle) && go;
  assign unused_mo_hi = ^mo_data[31:8];

  always_comb begin
    state_d = state_q;  dw_d = dw_q;  rw_d = rw_q;  rh_d = rh_q;  n_d = n_q;  cnt_d = cnt_q;
    s_ready_d = s_ready_q;  start_d = 1'b0;  busy_d = busy_q;  done_d = 1'b0;  err_d = 1'b0;
    m_valid_d = m_valid_q;  m_last_d = m_last_q;  m_data_d = m_data_q;  pend_d = pend_q;
    col_d = col_q;  row_d = row_q;  base_d = base_q;  mo_addr_d = mo_addr_q;
    case (state_q)
      StIdle: begin
        if (go) begin
          if (n_go == 16'd0 || 32'(n_go) > DSIZE) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            dw_d      = data_width;
            rw_d      = result_width;
            rh_d      = result_height;
            n_d       = n_go;
            cnt_d     = 16'd0;
            s_ready_d = 1'b1;
            busy_d    = 1'b1;
            state_d   = StLoad;
          end
        end
      end
      StLoad: begin
        if (s_hs) begin
          cnt_d = cnt_q + 16'd1;
          if (byte_last) begin
            s_ready_d = 1'b0;
            state_d   = StKick;
          end
        end
      end
      StKick: begin
        start_d = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (conv_done) begin
          col_d     = 8'd0;
          row_d     = 8'd0;
          base_d    = 16'd0;
          mo_addr_d = '0;
          pend_d    = 1'b1;
          state_d   = StDrain;
        end
      end
      StDrain: begin
        if (m_hs) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (m_last_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
        // mo_addr_q already points at the byte to capture; advance it as we take it.
        if (pend_q && (!m_valid_q || m_ready)) begin
          m_valid_d = 1'b1;
          m_data_d  = mo_data[7:0];
          m_last_d  = rd_last;
          if (rd_last) begin
            pend_d = 1'b0;
          end else if (col_q == rw_q) begin
            col_d     = 8'd0;
            row_d     = row_q + 8'd1;
            base_d    = base_q + 16'(dw_q);
            mo_addr_d = AW'(base_q + 16'(dw_q));
          end else begin
            col_d     = col_q + 8'd1;
            mo_addr_d = AW'(base_q + 16'(col_q) + 16'd1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;  dw_q <= 8'd0;  rw_q <= 8'd0;  rh_q <= 8'd0;
      n_q <= 16'd0;  cnt_q <= 16'd0;  s_ready_q <= 1'b0;  start_q <= 1'b0;
      busy_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;
      m_valid_q <= 1'b0;  m_last_q <= 1'b0;  m_data_q <= 8'd0;  pend_q <= 1'b0;
      col_q <= 8'd0;  row_q <= 8'd0;  base_q <= 16'd0;  mo_addr_q <= '0;
    end else begin
      state_q <= state_d;  dw_q <= dw_d;  rw_q <= rw_d;  rh_q <= rh_d;
      n_q <= n_d;  cnt_q <= cnt_d;  s_ready_q <= s_ready_d;  start_q <= start_d;
      busy_q <= busy_d;  done_q <= done_d;  err_q <= err_d;
      m_valid_q <= m_valid_d;  m_last_q <= m_last_d;  m_data_q <= m_data_d;  pend_q <= pend_d;
      col_q <= col_d;  row_q <= row_d;  base_q <= base_d;  mo_addr_q <= mo_addr_d;
    end
  end

  logic [AW-3:0] word_idx;

  conv_byte_packer #(
    .IdxW(AW - 2)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (pack_clear),
    .byte_valid_i(s_hs),
    .byte_i      (s_data),
    .byte_last_i (byte_last),
    .word_o      (mi_data),
    .word_valid_o(mi_wr),
    .word_idx_o  (word_idx)
  );

  assign mi_addr    = {word_idx, 2'b00};
  assign s_ready    = s_ready_q;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign mo_addr    = mo_addr_q;
  assign conv_start = start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_conv_host_sequencer.sv
// Scoreboard bench for conv_host_sequencer with a behavioural accelerator output memory.
module tb_conv_host_sequencer;

  localparam int unsigned DSIZE = 1024;
  localparam int AW = 11;

  logic          clk, rst, go;
  logic [7:0]    data_width, data_height, result_width, result_height;
  logic [7:0]    s_data, m_data;
  logic          s_valid, s_ready, m_valid, m_ready, m_last;
  logic [AW-1:0] mi_addr, mo_addr;
  logic [31:0]   mi_data, mo_data;
  logic          mi_wr, conv_start, conv_done, busy, done, err;

  conv_host_sequencer #(.DSIZE(DSIZE)) dut (
    .clk(clk), .rst(rst), .go(go),
    .data_width(data_width), .data_height(data_height),
    .result_width(result_width), .result_height(result_height),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .mi_addr(mi_addr), .mi_data(mi_data), .mi_wr(mi_wr),
    .mo_addr(mo_addr), .mo_data(mo_data),
    .conv_start(conv_start), .conv_done(conv_done),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    logic [7:0] t;
    t = a[7:0];
    return t * 8'd3 + 8'd7;
  endfunction

  assign mo_data = {24'hDEADBE, mem_byte(mo_addr)};

  logic [AW+31:0] wr_q[$];
  logic [8:0]     out_q[$];
  int n_checks = 0, n_errors = 0;
  int wr_cnt = 0, start_cnt = 0, done_cnt = 0, err_cnt = 0;
  int last_wr_cyc = 0, start_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  logic           prev_hold = 1'b0, prev_last;
  logic [7:0]     prev_data;
  logic [AW+31:0] we;
  logic [8:0]     oe;
  logic           tog = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (mi_wr) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        check_eq("wr_expected", 64'(wr_q.size() != 0), 64'd1);
        if (wr_q.size() != 0) begin
          we = wr_q.pop_front();
          check_eq("wr_addr", 64'(mi_addr), 64'(we[AW+31:32]));
          check_eq("wr_data", 64'(mi_data), 64'(we[31:0]));
        end
      end
      if (conv_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (prev_hold) begin
        check_eq("hold_valid", 64'(m_valid), 64'd1);
        check_eq("hold_data_last", 64'({m_last, m_data}), 64'({prev_last, prev_data}));
      end
      if (m_valid && m_ready) begin
        check_eq("out_expected", 64'(out_q.size() != 0), 64'd1);
        if (out_q.size() != 0) begin
          oe = out_q.pop_front();
          check_eq("out_byte_last", 64'({m_last, m_data}), 64'(oe));
        end
        if (m_last) last_hs_cyc = cyc;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (err) err_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    #1 m_ready = tog ? ~m_ready : 1'b1;
  end

  task automatic check_reset_outs(input string tag);
    check_eq(tag, 64'({s_ready, m_valid, m_last, m_data, mi_wr, mi_addr}), 64'd0);
    check_eq({tag, "_data"}, 64'({mi_data, mo_addr, conv_start, busy, done, err}), 64'd0);
  endtask

  task automatic pulse_go(input logic [7:0] dw, dh, rw, rh);
    @(posedge clk); #1;
    data_width = dw; data_height = dh; result_width = rw; result_height = rh;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic send_bytes(input int n, input logic [7:0] base, input logic [7:0] step);
    int i = 0;
    int guard = 0;
    logic hs;
    while (i < n && guard < 1000) begin
      s_valid = 1'b1;
      s_data  = base + 8'(i) * step;
      @(negedge clk) hs = s_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    s_valid = 1'b0;
    if (i != n) check_eq("send_timeout", 64'(i), 64'(n));
  endtask

  task automatic wait_start(input int n);
    for (int k = 0; k < 200 && start_cnt < n; k++) begin
      @(posedge clk); #1;
    end
    check_eq("start_seen", 64'(start_cnt), 64'(n));
  endtask

  task automatic wait_done(input int prev);
    for (int k = 0; k < 200 && done_cnt <= prev; k++) begin
      @(posedge clk); #1;
    end
    check_eq("done_seen", 64'(done_cnt), 64'(prev + 1));
  endtask

  task automatic pulse_cdone();
    conv_done = 1'b1;
    @(posedge clk); #1;
    conv_done = 1'b0;
  endtask

  task automatic push_word(input logic [AW-1:0] a, input logic [31:0] d);
    wr_q.push_back({a, d});
  endtask

  task automatic push_drain(input int dw, input int rw, input int rh);
    logic [AW-1:0] a;
    for (int r = 0; r <= rh; r++) begin
      for (int c = 0; c <= rw; c++) begin
        a = AW'(c + dw * r);
        out_q.push_back({(c == rw && r == rh), mem_byte(a)});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int prev_done, prev_wr, prev_start;

  initial begin
    rst = 1'b1; go = 1'b0; s_valid = 1'b0; s_data = 8'd0; conv_done = 1'b0; m_ready = 1'b1;
    data_width = 8'd0; data_height = 8'd0; result_width = 8'd0; result_height = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk) check_reset_outs("reset_outs");
    @(posedge clk); #1 rst = 1'b0;

    // 4x4 load, then a drain with backpressure.
    push_word(11'd0, 32'h03020100);  push_word(11'd4, 32'h07060504);
    push_word(11'd8, 32'h0B0A0908);  push_word(11'd12, 32'h0F0E0D0C);
    pulse_go(8'd4, 8'd4, 8'd1, 8'd1);
    @(negedge clk);
    check_eq("busy_after_go", 64'({busy, s_ready}), 64'b11);
    @(posedge clk); #1;
    send_bytes(16, 8'h00, 8'h01);
    wait_start(1);
    check_eq("start_after_last_wr", 64'(start_cyc), 64'(last_wr_cyc + 1));
    check_eq("wr_count_4x4", 64'(wr_cnt), 64'd4);
    prev_done = done_cnt;
    pulse_go(8'd40, 8'd40, 8'd0, 8'd0);
    @(negedge clk);
    check_eq("go_in_wait_ignored", 64'({done, err, s_ready, busy}), 64'b0001);
    repeat (3) @(posedge clk); #1;
    check_eq("no_done_in_wait", 64'(done_cnt), 64'(prev_done));
    tog = 1'b1;
    push_drain(4, 1, 1);
    pulse_cdone();
    wait_done(prev_done);
    tog = 1'b0;
    check_eq("drain_queue_empty", 64'(out_q.size()), 64'd0);
    check_eq("done_after_last_hs", 64'(done_cyc), 64'(last_hs_cyc + 1));
    check_eq("no_err_4x4", 64'(err_cnt), 64'd0);
    check_eq("idle_after_done", 64'(busy), 64'd0);

    // 3x3 load with a stray conv_done mid-load.
    push_word(11'd0, 32'h03020100);  push_word(11'd4, 32'h07060504);
    push_word(11'd8, 32'h00000008);
    pulse_go(8'd3, 8'd3, 8'd2, 8'd0);
    send_bytes(4, 8'h00, 8'h01);
    pulse_cdone();
    send_bytes(5, 8'h04, 8'h01);
    wait_start(2);
    check_eq("wr_count_3x3", 64'(wr_cnt), 64'd7);
    check_eq("wr_queue_3x3", 64'(wr_q.size()), 64'd0);
    prev_done = done_cnt;
    push_drain(3, 2, 0);
    pulse_cdone();
    wait_done(prev_done);
    check_eq("drain_queue_3x3", 64'(out_q.size()), 64'd0);

    // Oversized image is rejected.
    prev_done = done_cnt; prev_wr = wr_cnt; prev_start = start_cnt;
    pulse_go(8'd40, 8'd40, 8'd0, 8'd0);
    @(negedge clk);
    check_eq("oversize_done_err", 64'({done, err}), 64'b11);
    repeat (5) @(posedge clk); #1;
    check_eq("oversize_no_activity", 64'({wr_cnt - prev_wr, start_cnt - prev_start}), 64'd0);
    check_eq("oversize_idle", 64'({busy, s_ready}), 64'd0);

    // Reset mid-load, then a fresh 2x2 job.
    push_word(11'd0, 32'h03020100);
    pulse_go(8'd4, 8'd4, 8'd0, 8'd0);
    send_bytes(6, 8'h00, 8'h01);
    #2 rst = 1'b1;
    #1 check_reset_outs("midload_reset");
    check_eq("midload_wr_queue", 64'(wr_q.size()), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    push_word(11'd0, 32'h33221100);
    pulse_go(8'd2, 8'd2, 8'd0, 8'd0);
    send_bytes(4, 8'h00, 8'h11);
    wait_start(start_cnt + 1);
    check_eq("wr_queue_2x2", 64'(wr_q.size()), 64'd0);
    prev_done = done_cnt;
    push_drain(2, 0, 0);
    pulse_cdone();
    wait_done(prev_done);
    check_eq("drain_queue_2x2", 64'(out_q.size()), 64'd0);
    check_eq("err_total", 64'(err_cnt), 64'd1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
